// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges the fetch (c0) and data (c1) request channels
// onto one core-to-cache bus, one transaction outstanding at a time.
// Ports: clk, reset (async, active-high); c0_*/c1_* client request and
// response channels; bus_* downstream request and response channel.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise client 1 wins ties.
module core_bus_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDRESS    = 64,
    parameter int TAG_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDRESS-1:0]    c0_req,
    input  logic [DATA_WIDTH-1:0] c0_reqdata,
    input  logic [TAG_WIDTH-1:0]  c0_reqtag,
    input  logic                  c0_reqcyc,
    output logic                  c0_reqack,
    output logic [DATA_WIDTH-1:0] c0_resp,
    output logic [TAG_WIDTH-1:0]  c0_resptag,
    output logic                  c0_respcyc,
    input  logic                  c0_respack,
    input  logic [ADDRESS-1:0]    c1_req,
    input  logic [DATA_WIDTH-1:0] c1_reqdata,
    input  logic [TAG_WIDTH-1:0]  c1_reqtag,
    input  logic                  c1_reqcyc,
    output logic                  c1_reqack,
    output logic [DATA_WIDTH-1:0] c1_resp,
    output logic [TAG_WIDTH-1:0]  c1_resptag,
    output logic                  c1_respcyc,
    input  logic                  c1_respack,
    output logic [ADDRESS-1:0]    bus_req,
    output logic [DATA_WIDTH-1:0] bus_reqdata,
    output logic [TAG_WIDTH-1:0]  bus_reqtag,
    output logic                  bus_reqcyc,
    input  logic                  bus_reqack,
    input  logic [DATA_WIDTH-1:0] bus_resp,
    input  logic [TAG_WIDTH-1:0]  bus_resptag,
    input  logic                  bus_respcyc,
    output logic                  bus_respack
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state, state_nxt;
    logic                  owner;
    logic [ADDRESS-1:0]    cap_req;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [TAG_WIDTH-1:0]  cap_tag;
    logic                  gnt0, gnt1;
`ifdef ARB_ROUND_ROBIN_EN
    logic                  last_grant;
`endif

    // Grant is only offered from IDLE; reset gating keeps reqack low
    // while reset is held even if clients are requesting.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && !reset) begin
            if (c0_reqcyc && c1_reqcyc) begin
`ifdef ARB_ROUND_ROBIN_EN
                gnt0 = last_grant;
                gnt1 = ~last_grant;
`else
                gnt1 = 1'b1;
`endif
            end else begin
                gnt0 = c0_reqcyc;
                gnt1 = c1_reqcyc;
            end
        end
    end

    assign c0_reqack   = gnt0;
    assign c1_reqack   = gnt1;
    assign bus_req     = cap_req;
    assign bus_reqdata = cap_data;
    assign bus_reqtag  = cap_tag;

    always_comb begin
        state_nxt   = state;
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        c0_respcyc  = 1'b0;
        c0_resp     = '0;
        c0_resptag  = '0;
        c1_respcyc  = 1'b0;
        c1_resp     = '0;
        c1_resptag  = '0;
        case (state)
            IDLE: begin
                if (gnt0 || gnt1)
                    state_nxt = REQ;
            end
            REQ: begin
                bus_reqcyc = 1'b1;
                // Writes expect no response from the cache side.
                if (bus_reqack)
                    state_nxt = cap_tag[TAG_WIDTH-1] ? RESP : IDLE;
            end
            RESP: begin
                if (bus_respcyc) begin
                    if (owner) begin
                        c1_respcyc  = 1'b1;
                        c1_resp     = bus_resp;
                        c1_resptag  = bus_resptag;
                        bus_respack = c1_respack;
                    end else begin
                        c0_respcyc  = 1'b1;
                        c0_resp     = bus_resp;
                        c0_resptag  = bus_resptag;
                        bus_respack = c0_respack;
                    end
                end
                if (bus_respcyc && bus_respack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            cap_req  <= '0;
            cap_data <= '0;
            cap_tag  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (gnt0 || gnt1) begin
                owner    <= gnt1;
                cap_req  <= gnt1 ? c1_req     : c0_req;
                cap_data <= gnt1 ? c1_reqdata : c0_reqdata;
                cap_tag  <= gnt1 ? c1_reqtag  : c0_reqtag;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant <= gnt1;
`endif
            end
        end
    end

endmodule
